// File: rtl/ec_pkg.sv
// Shared curve definitions for the EC point encoder: curve select encoding,
// coordinate byte lengths and SEC1 header octets.
package ec_pkg;

    localparam int unsigned MAX_COORD_BYTES = 66;

    localparam logic [7:0] HDR_UNCOMP = 8'h04;
    localparam logic [7:0] HDR_EVEN   = 8'h02;
    localparam logic [7:0] HDR_ODD    = 8'h03;

    typedef enum logic [1:0] {
        CURVE_P256 = 2'd0,
        CURVE_P384 = 2'd1,
        CURVE_P521 = 2'd2,
        CURVE_BAD  = 2'd3
    } curve_e;

    function automatic logic [6:0] coord_len(input curve_e c);
        case (c)
            CURVE_P256: coord_len = 7'd32;
            CURVE_P384: coord_len = 7'd48;
            CURVE_P521: coord_len = 7'd66;
            default:    coord_len = 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/ec_point_encoder_byte_sel.sv
// Combinational picker for byte idx (MSB-first) of a right-aligned coordinate
// of length len bytes.
module ec_byte_sel #(
    parameter int unsigned MAX_COORD_BYTES = ec_pkg::MAX_COORD_BYTES
) (
    input  logic [8*MAX_COORD_BYTES-1:0] coord,
    input  logic [6:0]                   len,
    input  logic [6:0]                   idx,
    output logic [7:0]                   byte_out
);

    logic [6:0] pos;

    always_comb begin
        pos      = len - 7'd1 - idx;
        byte_out = '0;
        for (int unsigned k = 0; k < MAX_COORD_BYTES; k++) begin
            if (7'(k) == pos) byte_out = coord[8*k +: 8];
        end
    end

endmodule

// File: rtl/ec_point_encoder.sv
// Streams an affine EC point as SEC1 octets (0x04 || X || Y), one byte per
// handshake. Compressed form (0x02/0x03 || X) is built with EC_POINT_COMPRESSED_EN.
module ec_point_encoder #(
    parameter int unsigned MAX_COORD_BYTES = ec_pkg::MAX_COORD_BYTES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   curve_sel,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [8*MAX_COORD_BYTES-1:0] in_x,
    input  logic [8*MAX_COORD_BYTES-1:0] in_y,
    input  logic                         in_compress,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   out_data,
    output logic                         out_last,
    output logic                         err,
    output logic                         busy
);
    import ec_pkg::*;

    localparam int unsigned W = 8*MAX_COORD_BYTES;

    typedef enum logic [2:0] {IDLE, HDR, XOUT, YOUT, ERR} state_e;

    state_e     state;
    logic [W-1:0] x_r, y_r, sel_coord;
    logic [6:0] len_r, idx, len_in, nxt_idx;
    logic [7:0] hdr_byte, nxt_byte;
    logic       over, take, x_done, y_done, nxt_use_y, nxt_last, comp_act;

`ifdef EC_POINT_COMPRESSED_EN
    logic comp_r;
`else
    logic unused_compress;
    assign unused_compress = in_compress;
`endif

    always_comb begin
        len_in = coord_len(curve_e'(curve_sel));
        over   = 1'b0;
        for (int unsigned k = 0; k < MAX_COORD_BYTES; k++) begin
            if (7'(k) >= len_in) over = over | (|in_x[8*k +: 8]) | (|in_y[8*k +: 8]);
        end

        hdr_byte = HDR_UNCOMP;
        comp_act = 1'b0;
`ifdef EC_POINT_COMPRESSED_EN
        if (in_compress) hdr_byte = in_y[0] ? HDR_ODD : HDR_EVEN;
        comp_act = comp_r;
`endif

        // out_data is registered, so the selector always looks one byte ahead
        take      = out_valid && out_ready;
        x_done    = (state == XOUT) && (idx == len_r - 7'd1);
        y_done    = (state == YOUT) && (idx == len_r - 7'd1);
        nxt_use_y = (state == YOUT) || x_done;
        nxt_idx   = ((state == HDR) || x_done) ? '0 : idx + 7'd1;
        nxt_last  = (nxt_idx == len_r - 7'd1) && (nxt_use_y || comp_act);
        sel_coord = nxt_use_y ? y_r : x_r;
    end

    ec_byte_sel #(.MAX_COORD_BYTES(MAX_COORD_BYTES)) u_byte_sel (
        .coord    (sel_coord),
        .len      (len_r),
        .idx      (nxt_idx),
        .byte_out (nxt_byte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            x_r       <= '0;
            y_r       <= '0;
            len_r     <= '0;
            idx       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
`ifdef EC_POINT_COMPRESSED_EN
            comp_r    <= 1'b0;
`endif
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    if (in_valid && in_ready) begin
                        x_r      <= in_x;
                        y_r      <= in_y;
                        len_r    <= len_in;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef EC_POINT_COMPRESSED_EN
                        comp_r   <= in_compress;
`endif
                        if (curve_e'(curve_sel) == CURVE_BAD || over) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else begin
                            state     <= HDR;
                            out_valid <= 1'b1;
                            out_data  <= hdr_byte;
                            out_last  <= 1'b0;
                        end
                    end
                end
                HDR: begin
                    if (take) begin
                        state    <= XOUT;
                        idx      <= nxt_idx;
                        out_data <= nxt_byte;
                        out_last <= nxt_last;
                    end
                end
                XOUT, YOUT: begin
                    if (take) begin
                        if (y_done || (x_done && comp_act)) begin
                            state     <= IDLE;
                            idx       <= '0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            if (x_done) state <= YOUT;
                            idx      <= nxt_idx;
                            out_data <= nxt_byte;
                            out_last <= nxt_last;
                        end
                    end
                end
                ERR: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ec_point_encoder.sv
// Randomized self-checking bench for ec_point_encoder against a byte-queue
// model of the SEC1 encoding; honours EC_POINT_COMPRESSED_EN like the DUT.
module tb_ec_point_encoder;

    localparam int unsigned MAXB = 66;
    localparam int unsigned W    = 8*MAXB;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   curve_sel;
    logic         in_valid, in_ready;
    logic [W-1:0] in_x, in_y;
    logic         in_compress;
    logic         out_valid, out_ready;
    logic [7:0]   out_data;
    logic         out_last, err, busy;

    int total_n = 0;
    int bad_n   = 0;

    always #5 clk = ~clk;

    ec_point_encoder #(.MAX_COORD_BYTES(MAXB)) dut (
        .clk         (clk),
        .rst         (rst),
        .curve_sel   (curve_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_compress (in_compress),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .err         (err),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_n++;
        if (got !== exp) begin
            bad_n++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned len_of(input logic [1:0] cs);
        case (cs)
            2'd0:    return 32;
            2'd1:    return 48;
            2'd2:    return 66;
            default: return 0;
        endcase
    endfunction

    function automatic logic [W-1:0] rand_coord(input int unsigned nbytes);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < int'(nbytes); i++) v[8*i +: 8] = 8'($urandom);
        return v;
    endfunction

    task automatic scramble();
        in_valid    = 1'($urandom);
        curve_sel   = 2'($urandom);
        in_x        = rand_coord(MAXB);
        in_y        = rand_coord(MAXB);
        in_compress = 1'($urandom);
    endtask

    task automatic wait_ready(input string tag);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
    endtask

    // mode 0: out_ready always 1, 1: toggle 1/0, 2: random
    task automatic run_point(input logic [1:0] cs, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic comp, input int mode, input string tag);
        byte unsigned exp_q[$];
        int unsigned  L;
        bit           bad_in, use_comp, stalled;
        int           cnt, guard;
        logic [7:0]   hold_d;
        logic         hold_l;

        L      = len_of(cs);
        bad_in = (cs == 2'd3) || ((x >> (8*L)) != '0) || ((y >> (8*L)) != '0);
        use_comp = 1'b0;
`ifdef EC_POINT_COMPRESSED_EN
        use_comp = comp;
`endif
        if (!bad_in) begin
            exp_q.push_back(use_comp ? (y[0] ? 8'h03 : 8'h02) : 8'h04);
            for (int i = 0; i < int'(L); i++) exp_q.push_back(8'(x >> (8*(int'(L)-1-i))));
            if (!use_comp)
                for (int i = 0; i < int'(L); i++) exp_q.push_back(8'(y >> (8*(int'(L)-1-i))));
        end

        wait_ready(tag);
        out_ready   = 1'b0;
        curve_sel   = cs;
        in_x        = x;
        in_y        = y;
        in_compress = comp;
        in_valid    = 1'b1;
        @(negedge clk);
        scramble();

        if (bad_in) begin
            check({tag, "/err_n1"}, 32'(err), 32'd1);
            check({tag, "/valid_n1"}, 32'(out_valid), 32'd0);
            @(negedge clk);
            in_valid = 1'b0;
            check({tag, "/err_n2"}, 32'(err), 32'd0);
            check({tag, "/valid_n2"}, 32'(out_valid), 32'd0);
            check({tag, "/in_ready_n2"}, 32'(in_ready), 32'd1);
        end else begin
            check({tag, "/hdr_latency"}, 32'(out_valid), 32'd1);
            cnt = 0;
            guard = 0;
            stalled = 1'b0;
            while (cnt < exp_q.size() && guard < 2000) begin
                check({tag, "/valid"}, 32'(out_valid), 32'd1);
                check({tag, "/in_ready_busy"}, 32'(in_ready), 32'd0);
                if (stalled) begin
                    check({tag, "/hold_data"}, 32'(out_data), 32'(hold_d));
                    check({tag, "/hold_last"}, 32'(out_last), 32'(hold_l));
                end
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (guard % 2 == 0);
                    default: out_ready = 1'($urandom);
                endcase
                if (out_ready) begin
                    check({tag, "/data"}, 32'(out_data), 32'(exp_q[cnt]));
                    check({tag, "/last"}, 32'(out_last), 32'(cnt == exp_q.size() - 1));
                    cnt++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hold_d  = out_data;
                    hold_l  = out_last;
                end
                scramble();
                @(negedge clk);
                guard++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            check({tag, "/byte_count"}, 32'(cnt), 32'(exp_q.size()));
            if (mode == 0) check({tag, "/no_bubbles"}, 32'(guard), 32'(exp_q.size()));
            check({tag, "/valid_end"}, 32'(out_valid), 32'd0);
            check({tag, "/in_ready_end"}, 32'(in_ready), 32'd1);
            check({tag, "/busy_end"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic reset_mid_stream();
        int cnt, guard;
        wait_ready("rst_mid");
        curve_sel   = 2'd0;
        in_x        = rand_coord(32);
        in_y        = rand_coord(32);
        in_compress = 1'b0;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        guard = 0;
        while (cnt < 19 && guard < 100) begin
            if (out_valid) cnt++;
            @(negedge clk);
            guard++;
        end
        check("rst_mid/byte20_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid/out_valid", 32'(out_valid), 32'd0);
        check("rst_mid/out_data", 32'(out_data), 32'd0);
        check("rst_mid/out_last", 32'(out_last), 32'd0);
        check("rst_mid/in_ready", 32'(in_ready), 32'd0);
        check("rst_mid/err", 32'(err), 32'd0);
        check("rst_mid/busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("rst_mid/in_ready_after", 32'(in_ready), 32'd1);
        check("rst_mid/no_bytes", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [W-1:0] xv, yv;
        logic [1:0]   cs;
        int unsigned  L;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        curve_sel = 2'd0;
        in_x = '0;
        in_y = '0;
        in_compress = 1'b0;
        #12;
        check("reset/in_ready", 32'(in_ready), 32'd0);
        check("reset/out_valid", 32'(out_valid), 32'd0);
        check("reset/out_data", 32'(out_data), 32'd0);
        check("reset/out_last", 32'(out_last), 32'd0);
        check("reset/err", 32'(err), 32'd0);
        check("reset/busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset/in_ready_first_edge", 32'(in_ready), 32'd1);

        run_point(2'd0, W'(1), W'(2), 1'b0, 0, "p256_x1_y2");

        xv = '0;
        xv[520] = 1'b1;
        run_point(2'd2, xv, '0, 1'b0, 0, "p521_x2pow520");

        run_point(2'd1, rand_coord(48), rand_coord(48), 1'b0, 1, "p384_toggle");

        run_point(2'd3, rand_coord(32), rand_coord(32), 1'b0, 0, "bad_curve");
        xv = rand_coord(32);
        xv[256] = 1'b1;
        run_point(2'd0, xv, rand_coord(32), 1'b0, 0, "p256_x_bit256");

        reset_mid_stream();
        run_point(2'd0, rand_coord(32), rand_coord(32), 1'b0, 0, "after_reset");

        run_point(2'd0, rand_coord(32), W'(3), 1'b1, 0, "p256_comp_y3");
        run_point(2'd1, rand_coord(48), W'(8), 1'b1, 2, "p384_comp_yeven");

        for (int n = 0; n < 16; n++) begin
            cs = 2'($urandom);
            L  = len_of(cs);
            xv = rand_coord((cs == 2'd3) ? MAXB : L);
            yv = rand_coord((cs == 2'd3) ? MAXB : L);
            if (L < MAXB && L != 0 && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) xv[$urandom_range(8*L, W-1)] = 1'b1;
                else                            yv[$urandom_range(8*L, W-1)] = 1'b1;
            end
            run_point(cs, xv, yv, 1'($urandom), $urandom_range(0, 2), $sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule

// File: doc/ec_point_encoder.md
EC_POINT_ENCODER -- requirements
Module: ec_point_encoder

Interface
REQ-001 SHALL have parameter MAX_COORD_BYTES, default 66: maximum coordinate length in bytes (P-521).
REQ-002 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port curve_sel, input, 2: curve select. 0=P-256 (L=32), 1=P-384 (L=48), 2=P-521 (L=66), 3=invalid.
REQ-005 SHALL have port in_valid, input, 1: affine point offered.
REQ-006 SHALL have port in_ready, output, 1: encoder accepts a point.
REQ-007 SHALL have ports in_x and in_y, input, 8*MAX_COORD_BYTES each: affine X and Y, unsigned, right-aligned.
REQ-008 SHALL have port in_compress, input, 1: request compressed form. Present in both builds; ignored unless EC_POINT_COMPRESSED_EN is defined.
REQ-009 SHALL have port out_valid, output, 1: out_data holds a valid byte.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the byte.
REQ-011 SHALL have port out_data, output, 8: encoded octet.
REQ-012 SHALL have port out_last, output, 1: final byte of the encoding.
REQ-013 SHALL have port err, output, 1: one-cycle pulse when an input is rejected.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-015 SHALL use a state machine with states IDLE, HDR, XOUT, YOUT and ERR.
REQ-016 SHALL drive in_ready=1 only in IDLE. A handshake (in_valid && in_ready) in cycle N SHALL capture curve_sel, in_x, in_y and in_compress.
REQ-017 SHALL reject the captured point when curve_sel=3 or when any bit at or above 8*L in in_x or in_y is nonzero. Rejection: go to ERR, err=1 in cycle N+1 only, no bytes emitted, back to IDLE (in_ready=1) in N+2.
REQ-018 For an accepted point, SHALL present the header byte in HDR at cycle N+1 (first-byte latency 1).
- Header 0x04 for uncompressed output.
REQ-019 SHALL produce the uncompressed stream 0x04 || X || Y. Each coordinate is big-endian, MSB first, zero-padded to exactly L bytes. Total 1+2L bytes.
REQ-020 SHALL advance one byte per cycle in which out_valid && out_ready. A 7-bit byte index SHALL count 0..L-1 within XOUT and YOUT.
- Transitions: HDR->XOUT on header accept; XOUT->YOUT when byte L-1 is accepted; YOUT->IDLE when byte L-1 is accepted.
REQ-021 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-022 SHALL assert out_last only with the final byte of the stream.
REQ-023 SHALL sustain one byte per cycle under continuous out_ready=1, with no bubbles between header, X and Y.
REQ-024 SHALL ignore in_valid and all input data while busy. Changes on those inputs SHALL NOT affect the stream in flight.

Reset
REQ-025 On rst, SHALL immediately (asynchronously) force state=IDLE, byte index=0, and in_ready=0, out_valid=0, out_data=0, out_last=0, err=0, busy=0.
REQ-026 SHALL drive in_ready=1 from the first clock edge after rst deasserts.
REQ-027 SHALL, when reset is asserted mid-stream, abort the stream with no further bytes. The next accepted point SHALL start again with a header byte.

Configuration
REQ-028 Macro EC_POINT_COMPRESSED_EN defined:
- When the captured in_compress=1, SHALL emit header 0x02 (Y even) or 0x03 (Y odd), then X only.
- Total 1+L bytes; out_last on X byte L-1; YOUT skipped.
REQ-029 Macro undefined: in_compress SHALL be ignored, and the parity/compression logic SHALL be absent.

Structure
REQ-030 Package ec_pkg SHALL hold:
- the curve_sel enum;
- the function mapping curve to coordinate byte length;
- constants 0x04, 0x02 and 0x03;
- MAX_COORD_BYTES.
REQ-031 SHALL use one sub-module, ec_byte_sel: combinational selection of byte index i (MSB-first, length L) from a coordinate register. It is instantiated once and shared between XOUT and YOUT.

Verification
REQ-032 P-256, X=1, Y=2, out_ready=1 -> 65 bytes: 0x04, 31x00, 0x01, 31x00, 0x02. Header at N+1; out_last only on byte 65.
REQ-033 P-521, X=2^520, Y=0 -> 133 bytes; byte 2 = 0x01, bytes 3..67 = 0x00; out_last on byte 133.
REQ-034 P-384, out_ready toggling 1/0 each cycle -> 97 bytes, data stable on stalled cycles, in_ready=0 until final byte accepted.
REQ-035 curve_sel=3, and separately P-256 with in_x bit 256 set -> err=1 for exactly one cycle at N+1, out_valid stays 0, in_ready=1 at N+2.
REQ-036 rst asserted while byte 20 is presented -> all outputs 0 in the same cycle; next point restarts with 0x04.
REQ-037 With EC_POINT_COMPRESSED_EN, P-256, in_compress=1, Y=3 -> 33 bytes 0x03 || X. Without the macro, same stimulus -> 65 bytes starting 0x04.
